// File: rtl/spi_pkg.sv
// Shared SPI definitions: default widths, receiver FSM states and the
// mode-0 clock polarity/phase constants used by both bus partners.
package spi_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;

  // Mode 0: sclk idles low, data sampled on the rising edge.
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_SHIFT     = 2'd2
  } state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-stage input synchroniser with a history flop; exposes the synced
// level and one-cycle rise/fall pulses derived from it.
module spi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic data_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  // Shift the pin through the chain; the history flop trails the last stage.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign data_o = sync_q[SYNC_STAGES-1];
  assign rise_o = data_o & ~hist_q;
  assign fall_o = ~data_o & hist_q;

endmodule

// File: rtl/spi_rx_slave.sv
// SPI mode-0 slave receiver: oversamples the bus, deserialises MOSI words
// MSB first, returns a reply word on MISO and flags aborted frames.
module spi_rx_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SPI_sclk,
  input  logic              SPI_csn,
  input  logic              SPI_mosi,
  output logic              SPI_miso,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_load,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  // Synchronisers start low: csn then reads as "selected" until the pin is
  // genuinely high, which keeps a frame in flight at reset release ignored.
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(SPI_sclk),
    .data_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_csn (
    .clk(clk), .rst(rst), .din(SPI_csn),
    .data_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(SPI_mosi),
    .data_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                word_done_q, word_done_d;
  logic                rx_valid_q, rx_valid_d;
  logic                tx_load_q, tx_load_d;
  logic                frame_err_q, frame_err_d;
  logic                miso_q, miso_d;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_WAIT_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; a chip-select release always ends the frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_IDLE: if (cs_s)    state_d = ST_IDLE;
      ST_IDLE:      if (cs_fall) state_d = ST_SHIFT;
      ST_SHIFT:     if (cs_rise) state_d = ST_IDLE;
      default:                   state_d = ST_WAIT_IDLE;
    endcase
  end

  // FSM outputs and datapath: shifting, word completion, reply reload.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    word_done_d = 1'b0;
    tx_load_d   = 1'b0;
    frame_err_d = 1'b0;
    // A completed word is published one cycle after its last bit is shifted in.
    rx_valid_d  = word_done_q;
    rx_data_d   = word_done_q ? rx_shift_q : rx_data_q;
    miso_d      = tx_shift_q[DATA_W-1];

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          tx_shift_d = tx_data;
          tx_load_d  = 1'b1;
          bit_cnt_d  = '0;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          // A coincident sclk edge is dropped; a partial word is discarded.
          frame_err_d = (bit_cnt_q != '0);
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d   = '0;
            word_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall) begin
          // A falling edge with the counter at zero follows a completed word.
          if (bit_cnt_q == '0) begin
            tx_shift_d = tx_data;
            tx_load_d  = 1'b1;
          end else begin
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      word_done_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_load_q   <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      word_done_q <= word_done_d;
      rx_valid_q  <= rx_valid_d;
      tx_load_q   <= tx_load_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
    end
  end

  assign SPI_miso  = miso_q;
  assign tx_load   = tx_load_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_spi_rx_slave.sv
// Directed bench for spi_rx_slave: a bit-banged mode-0 master drives the
// bus while a monitor counts output pulses and logs received words.
module tb_spi_rx_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       SPI_sclk, SPI_csn, SPI_mosi, SPI_miso;
  logic [7:0] tx_data, rx_data;
  logic       tx_load, rx_valid, frame_err, busy;

  int checks = 0;
  int errors = 0;

  int         vld_cnt  = 0;
  int         load_cnt = 0;
  int         ferr_cnt = 0;
  int         busy_cnt = 0;
  logic [7:0] rx_log[$];

  spi_rx_slave dut (
    .clk(clk), .rst(rst),
    .SPI_sclk(SPI_sclk), .SPI_csn(SPI_csn), .SPI_mosi(SPI_mosi), .SPI_miso(SPI_miso),
    .tx_data(tx_data), .tx_load(tx_load),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      vld_cnt <= vld_cnt + 1;
      rx_log.push_back(rx_data);
    end
    if (tx_load)   load_cnt <= load_cnt + 1;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (busy)      busy_cnt <= busy_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Master: nbits MSB-first bits, each with half-clk low then high phases.
  task automatic spi_bits(input logic [7:0] mosi_b, input int nbits, input int half,
                          output logic [7:0] miso_b);
    miso_b = '0;
    for (int i = 0; i < nbits; i++) begin
      SPI_mosi = mosi_b[7-i];
      tick(half);
      miso_b   = {miso_b[6:0], SPI_miso};
      SPI_sclk = 1'b1;
      tick(half);
      SPI_sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [7:0] mosi_b, input logic [7:0] tx_b,
                           output logic [7:0] miso_b);
    tx_data = tx_b;
    SPI_csn = 1'b0;
    tick(4);
    spi_bits(mosi_b, 8, 4, miso_b);
    tick(4);
    SPI_csn = 1'b1;
    tick(8);
  endtask

  task automatic test_reset;
    rst = 1'b1; SPI_csn = 1'b1; SPI_sclk = 1'b0; SPI_mosi = 1'b0; tx_data = 8'h00;
    tick(3);
    checks++; if (SPI_miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", SPI_miso); end
    checks++; if (tx_load !== 1'b0) begin errors++; $display("FAIL reset_tx_load: got %b expected 0", tx_load); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    tick(6);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single;
    int v0, l0, f0;
    logic [7:0] m;
    v0 = vld_cnt; l0 = load_cnt; f0 = ferr_cnt;
    tx_data = 8'h3C;
    SPI_csn = 1'b0;
    tick(4);
    checks++; if (load_cnt - l0 !== 1) begin errors++; $display("FAIL single_tx_load_at_cs_fall: got %0d expected 1", load_cnt - l0); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    spi_bits(8'hA5, 8, 4, m);
    tick(4);
    SPI_csn = 1'b1;
    tick(8);
    checks++; if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL single_rx_valid_count: got %0d expected 1", vld_cnt - v0); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_rx_data: got %h expected a5", rx_data); end
    checks++; if (m !== 8'h3C) begin errors++; $display("FAIL single_miso: got %h expected 3c", m); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL single_frame_err: got %0d expected 0", ferr_cnt - f0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_multi_word;
    int v0, f0, base;
    logic [7:0] m [3];
    logic [7:0] mosi_v [3];
    logic [7:0] tx_v [4];
    mosi_v = '{8'h01, 8'h80, 8'hFF};
    tx_v   = '{8'h11, 8'h22, 8'h33, 8'h44};
    v0 = vld_cnt; f0 = ferr_cnt; base = rx_log.size();
    tx_data = tx_v[0];
    SPI_csn = 1'b0;
    tick(6);
    for (int w = 0; w < 3; w++) begin
      tx_data = tx_v[w+1];
      spi_bits(mosi_v[w], 8, 4, m[w]);
      tick(6);
    end
    SPI_csn = 1'b1;
    tick(8);
    checks++; if (vld_cnt - v0 !== 3) begin errors++; $display("FAIL multi_rx_valid_count: got %0d expected 3", vld_cnt - v0); end
    for (int w = 0; w < 3; w++) begin
      checks++;
      if (rx_log.size() <= base + w) begin
        errors++; $display("FAIL multi_rx_word%0d: got none expected %h", w, mosi_v[w]);
      end else if (rx_log[base+w] !== mosi_v[w]) begin
        errors++; $display("FAIL multi_rx_word%0d: got %h expected %h", w, rx_log[base+w], mosi_v[w]);
      end
      checks++; if (m[w] !== tx_v[w]) begin errors++; $display("FAIL multi_miso_word%0d: got %h expected %h", w, m[w], tx_v[w]); end
    end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL multi_frame_err: got %0d expected 0", ferr_cnt - f0); end
  endtask

  task automatic test_partial_frame;
    int v0, f0;
    logic [7:0] m;
    v0 = vld_cnt; f0 = ferr_cnt;
    tx_data = 8'h00;
    SPI_csn = 1'b0;
    tick(4);
    spi_bits(8'hF0, 5, 4, m);
    tick(4);
    SPI_csn = 1'b1;
    tick(8);
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL partial_frame_err: got %0d expected 1", ferr_cnt - f0); end
    checks++; if (vld_cnt - v0 !== 0) begin errors++; $display("FAIL partial_rx_valid: got %0d expected 0", vld_cnt - v0); end
    checks++; if (rx_data !== 8'hFF) begin errors++; $display("FAIL partial_rx_data_held: got %h expected ff", rx_data); end
    v0 = vld_cnt; f0 = ferr_cnt;
    spi_frame(8'h5A, 8'h96, m);
    checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL partial_next_rx_data: got %h expected 5a", rx_data); end
    checks++; if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL partial_next_valid: got %0d expected 1", vld_cnt - v0); end
    checks++; if (m !== 8'h96) begin errors++; $display("FAIL partial_next_miso: got %h expected 96", m); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL partial_next_frame_err: got %0d expected 0", ferr_cnt - f0); end
  endtask

  task automatic test_cs_coincide;
    int v0, f0;
    logic [7:0] m;
    v0 = vld_cnt; f0 = ferr_cnt;
    SPI_csn = 1'b0;
    tick(4);
    spi_bits(8'hE1, 7, 4, m);
    SPI_mosi = 1'b1;
    tick(4);
    SPI_sclk = 1'b1;
    SPI_csn  = 1'b1;
    tick(4);
    SPI_sclk = 1'b0;
    tick(8);
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL coincide_frame_err: got %0d expected 1", ferr_cnt - f0); end
    checks++; if (vld_cnt - v0 !== 0) begin errors++; $display("FAIL coincide_rx_valid: got %0d expected 0", vld_cnt - v0); end
    checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL coincide_rx_data_held: got %h expected 5a", rx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL coincide_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_frame;
    int v0, b0;
    logic [7:0] m;
    tx_data = 8'h99;
    SPI_csn = 1'b0;
    tick(4);
    spi_bits(8'hE7, 3, 4, m);
    rst = 1'b1;
    tick(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_in_reset: got %b expected 0", busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_rx_data_cleared: got %h expected 00", rx_data); end
    rst = 1'b0;
    v0 = vld_cnt; b0 = busy_cnt;
    spi_bits(8'hFF, 5, 4, m);
    tick(4);
    checks++; if (busy_cnt - b0 !== 0) begin errors++; $display("FAIL midrst_busy_cycles: got %0d expected 0", busy_cnt - b0); end
    SPI_csn = 1'b1;
    tick(8);
    checks++; if (vld_cnt - v0 !== 0) begin errors++; $display("FAIL midrst_rx_valid: got %0d expected 0", vld_cnt - v0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_after: got %b expected 0", busy); end
    v0 = vld_cnt;
    spi_frame(8'hC3, 8'h5C, m);
    checks++; if (rx_data !== 8'hC3) begin errors++; $display("FAIL midrst_next_rx_data: got %h expected c3", rx_data); end
    checks++; if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL midrst_next_valid: got %0d expected 1", vld_cnt - v0); end
    checks++; if (m !== 8'h5C) begin errors++; $display("FAIL midrst_next_miso: got %h expected 5c", m); end
  endtask

  task automatic test_loopback_random;
    int v0;
    logic [7:0] tx_wr_data, reply, m;
    for (int k = 0; k < 16; k++) begin
      tx_wr_data = 8'($urandom_range(0, 255));
      reply      = 8'($urandom_range(0, 255));
      v0 = vld_cnt;
      spi_frame(tx_wr_data, reply, m);
      checks++; if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL loop%0d_valid_count: got %0d expected 1", k, vld_cnt - v0); end
      checks++; if (rx_data !== tx_wr_data) begin errors++; $display("FAIL loop%0d_rx_data: got %h expected %h", k, rx_data, tx_wr_data); end
      checks++; if (m !== reply) begin errors++; $display("FAIL loop%0d_miso: got %h expected %h", k, m, reply); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_word();
    test_partial_frame();
    test_cs_coincide();
    test_reset_mid_frame();
    test_loopback_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
